hazard_unit_mc: RTL and testbench

Parametrised hazard controller for the 5-stage RV32 pipeline, extended for a multi-cycle multiply/divide unit in Execute. It forwards from Memory and Writeback to Execute and detects load-use hazards, with register-use qualification and x0 gating. A counter FSM holds Fetch, Decode and Execute for the duration of a multi-cycle op while bubbling Memory. It also keeps saturating performance counters for stall and flush cycles.

---
 rtl/hazard_unit_mc_if.sv | 38 +++
 rtl/hazard_unit_mc.sv | 114 +++++++++++
 tb/tb_hazard_unit_mc.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-to-hazard-unit signal bundle: register addresses and control in,
// stall/flush/forward selects and performance counters out.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              UseRs1D, UseRs2D;
    logic [1:0]        ResultSrcE;
    logic              RegWriteM, RegWriteW;
    logic              PCSrcE;
    logic              MdStartE;
    logic              CntClr;

    logic              StallF, StallD, StallE;
    logic              FlushD, FlushE, FlushM;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              MdBusy;
    logic [CNT_W-1:0]  LwStallCnt, MdStallCnt, FlushCnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output UseRs1D, UseRs2D, ResultSrcE, RegWriteM, RegWriteW,
        output PCSrcE, MdStartE, CntClr,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  ForwardAE, ForwardBE, MdBusy,
        input  LwStallCnt, MdStallCnt, FlushCnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  UseRs1D, UseRs2D, ResultSrcE, RegWriteM, RegWriteW,
        input  PCSrcE, MdStartE, CntClr,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output ForwardAE, ForwardBE, MdBusy,
        output LwStallCnt, MdStallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding, load-use stall,
// branch flush, multi-cycle mul/div hold FSM and saturating perf counters.
module hazard_unit_mc #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    hazard_unit_mc_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MD_LAT - 2);

    state_t           r_state, w_nextState;
    logic [3:0]       r_cnt, w_cntNext;
    logic             w_lwStall, w_mdStall;
    logic             w_rs1Hit, w_rs2Hit;
    logic [1:0]       w_fwdA, w_fwdB;
    logic [CNT_W-1:0] r_lwStallCnt, r_mdStallCnt, r_flushCnt;

    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rdM,
        input logic              wrM,
        input logic [REG_AW-1:0] rdW,
        input logic              wrW
    );
        if (rs != '0 && wrM && rs == rdM)
            return 2'b10;
        else if (rs != '0 && wrW && rs == rdW)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_fwdA = fwdSel(bus.Rs1E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
        w_fwdB = fwdSel(bus.Rs2E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
    end

    // A taken branch means Decode holds a wrong-path instruction, so no load-use stall.
    always_comb begin
        w_rs1Hit  = bus.UseRs1D && (bus.Rs1D == bus.RdE);
        w_rs2Hit  = bus.UseRs2D && (bus.Rs2D == bus.RdE);
        w_lwStall = bus.ResultSrcE[0] && (bus.RdE != '0) &&
                    (w_rs1Hit || w_rs2Hit) && !bus.PCSrcE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_cntNext;
        end
    end

    // MdStartE is ignored while BUSY so the op in Execute is not restarted.
    always_comb begin
        w_nextState = r_state;
        w_cntNext   = r_cnt;
        w_mdStall   = 1'b0;
        if (r_state == IDLE) begin
            if (bus.MdStartE) begin
                w_mdStall   = 1'b1;
                w_nextState = BUSY;
                w_cntNext   = CNT_INIT;
            end
        end else begin
            if (r_cnt != 4'd0) begin
                w_mdStall = 1'b1;
                w_cntNext = r_cnt - 4'd1;
            end else begin
                w_nextState = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lwStallCnt <= '0;
            r_mdStallCnt <= '0;
            r_flushCnt   <= '0;
        end else if (bus.CntClr) begin
            r_lwStallCnt <= '0;
            r_mdStallCnt <= '0;
            r_flushCnt   <= '0;
        end else begin
            if (w_lwStall && r_lwStallCnt != '1)
                r_lwStallCnt <= r_lwStallCnt + 1'b1;
            if (w_mdStall && r_mdStallCnt != '1)
                r_mdStallCnt <= r_mdStallCnt + 1'b1;
            if (bus.PCSrcE && r_flushCnt != '1)
                r_flushCnt <= r_flushCnt + 1'b1;
        end
    end

    // Execute is held, never flushed, while a mul/div op occupies it.
    assign bus.StallF     = w_lwStall || w_mdStall;
    assign bus.StallD     = w_lwStall || w_mdStall;
    assign bus.StallE     = w_mdStall;
    assign bus.FlushM     = w_mdStall;
    assign bus.FlushE     = (w_lwStall || bus.PCSrcE) && !w_mdStall;
    assign bus.FlushD     = bus.PCSrcE && !w_mdStall;
    assign bus.ForwardAE  = w_fwdA;
    assign bus.ForwardBE  = w_fwdB;
    assign bus.MdBusy     = (r_state == BUSY);
    assign bus.LwStallCnt = r_lwStallCnt;
    assign bus.MdStallCnt = r_mdStallCnt;
    assign bus.FlushCnt   = r_flushCnt;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (MD_LAT=4/CNT_W=32 and MD_LAT=2/CNT_W=4)
// checked each cycle against a remaining-occupancy model, plus directed literal checks.
module tb_hazard_unit_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0, rdE = '0, rdM = '0, rdW = '0;
    logic       useRs1D = 1'b0, useRs2D = 1'b0;
    logic [1:0] resultSrcE = 2'b00;
    logic       regWriteM = 1'b0, regWriteW = 1'b0, pcSrcE = 1'b0, mdStartE = 1'b0, cntClr = 1'b0;

    int checks = 0;
    int errors = 0;

    hazard_unit_mc_if #(.REG_AW(5), .CNT_W(32)) bus4 ();
    hazard_unit_mc_if #(.REG_AW(5), .CNT_W(4))  bus2 ();

    always_comb begin
        bus4.Rs1D = rs1D; bus4.Rs2D = rs2D; bus4.Rs1E = rs1E; bus4.Rs2E = rs2E;
        bus4.RdE = rdE; bus4.RdM = rdM; bus4.RdW = rdW;
        bus4.UseRs1D = useRs1D; bus4.UseRs2D = useRs2D; bus4.ResultSrcE = resultSrcE;
        bus4.RegWriteM = regWriteM; bus4.RegWriteW = regWriteW;
        bus4.PCSrcE = pcSrcE; bus4.MdStartE = mdStartE; bus4.CntClr = cntClr;
    end

    always_comb begin
        bus2.Rs1D = rs1D; bus2.Rs2D = rs2D; bus2.Rs1E = rs1E; bus2.Rs2E = rs2E;
        bus2.RdE = rdE; bus2.RdM = rdM; bus2.RdW = rdW;
        bus2.UseRs1D = useRs1D; bus2.UseRs2D = useRs2D; bus2.ResultSrcE = resultSrcE;
        bus2.RegWriteM = regWriteM; bus2.RegWriteW = regWriteW;
        bus2.PCSrcE = pcSrcE; bus2.MdStartE = mdStartE; bus2.CntClr = cntClr;
    end

    hazard_unit_mc #(.REG_AW(5), .MD_LAT(4), .CNT_W(32)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    hazard_unit_mc #(.REG_AW(5), .MD_LAT(2), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Model: remain = cycles the current mul/div op still occupies Execute (0 = free).
    localparam int     LAT[2]  = '{4, 2};
    localparam longint CMAX[2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
    int     remain[2];
    longint lwCnt[2], mdCnt[2], flCnt[2];

    function automatic logic [1:0] modelFwd(input logic [4:0] rs);
        if (rs != 0 && regWriteM && rs == rdM) return 2'b10;
        if (rs != 0 && regWriteW && rs == rdW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic modelLw();
        return resultSrcE[0] && rdE != 0 && !pcSrcE &&
               ((useRs1D && rs1D == rdE) || (useRs2D && rs2D == rdE));
    endfunction

    function automatic logic modelMd(input int k);
        return (remain[k] == 0 && mdStartE) || remain[k] > 1;
    endfunction

    function automatic longint cntNext(input longint c, input logic inc, input int k);
        if (cntClr) return 0;
        if (inc && c < CMAX[k]) return c + 1;
        return c;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                remain[k] <= 0;
                lwCnt[k]  <= 0;
                mdCnt[k]  <= 0;
                flCnt[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                remain[k] <= (remain[k] == 0) ? (mdStartE ? LAT[k] - 1 : 0) : remain[k] - 1;
                lwCnt[k]  <= cntNext(lwCnt[k], modelLw(), k);
                mdCnt[k]  <= cntNext(mdCnt[k], modelMd(k), k);
                flCnt[k]  <= cntNext(flCnt[k], pcSrcE, k);
            end
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareDut(input int k, input logic [10:0] ctl,
                              input longint lw, input longint md, input longint fl);
        logic       lwS, mdS;
        logic [10:0] exp;
        lwS = modelLw();
        mdS = modelMd(k);
        exp = {lwS | mdS, lwS | mdS, mdS, pcSrcE & ~mdS, (lwS | pcSrcE) & ~mdS, mdS,
               modelFwd(rs1E), modelFwd(rs2E), remain[k] > 0};
        checkOutput($sformatf("ctl dut%0d", k), longint'(ctl), longint'(exp));
        checkOutput($sformatf("lwCnt dut%0d", k), lw, lwCnt[k]);
        checkOutput($sformatf("mdCnt dut%0d", k), md, mdCnt[k]);
        checkOutput($sformatf("flCnt dut%0d", k), fl, flCnt[k]);
    endtask

    always @(negedge clk) begin
        compareDut(0, {bus4.StallF, bus4.StallD, bus4.StallE, bus4.FlushD, bus4.FlushE, bus4.FlushM,
                       bus4.ForwardAE, bus4.ForwardBE, bus4.MdBusy},
                   bus4.LwStallCnt, bus4.MdStallCnt, bus4.FlushCnt);
        compareDut(1, {bus2.StallF, bus2.StallD, bus2.StallE, bus2.FlushD, bus2.FlushE, bus2.FlushM,
                       bus2.ForwardAE, bus2.ForwardBE, bus2.MdBusy},
                   bus2.LwStallCnt, bus2.MdStallCnt, bus2.FlushCnt);
    end

    task automatic applyStimulus(input logic [4:0] r1D, r2D, r1E, r2E, rE, rM, rW,
                                 input logic u1, u2, input logic [1:0] rsrc,
                                 input logic wM, wW, pc, md, clr);
        @(posedge clk);
        #1;
        rs1D = r1D; rs2D = r2D; rs1E = r1E; rs2E = r2E; rdE = rE; rdM = rM; rdW = rW;
        useRs1D = u1; useRs2D = u2; resultSrcE = rsrc;
        regWriteM = wM; regWriteW = wW; pcSrcE = pc; mdStartE = md; cntClr = clr;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic mdCycle(input logic md);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, md, 0);
    endtask

    task automatic loadUse(input logic clr);
        applyStimulus(0, 7, 0, 0, 7, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, clr);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset StallF", bus4.StallF, 0);
        checkOutput("reset MdBusy", bus4.MdBusy, 0);
        checkOutput("reset LwStallCnt", bus4.LwStallCnt, 0);
        @(posedge clk); #1 rst = 1'b0;

        applyStimulus(0, 0, 5, 5, 0, 5, 5, 0, 0, 2'b00, 1, 1, 0, 0, 0); #2;
        checkOutput("fwd M A", bus4.ForwardAE, 2);
        checkOutput("fwd M B", bus4.ForwardBE, 2);
        applyStimulus(0, 0, 5, 5, 0, 5, 5, 0, 0, 2'b00, 0, 1, 0, 0, 0); #2;
        checkOutput("fwd W A", bus4.ForwardAE, 1);
        checkOutput("fwd W B", bus4.ForwardBE, 1);
        applyStimulus(0, 0, 0, 5, 0, 5, 5, 0, 0, 2'b00, 0, 1, 0, 0, 0); #2;
        checkOutput("fwd x0 A", bus4.ForwardAE, 0);

        loadUse(0); #2;
        checkOutput("lu StallF", bus4.StallF, 1);
        checkOutput("lu StallD", bus4.StallD, 1);
        checkOutput("lu FlushE", bus4.FlushE, 1);
        checkOutput("lu StallE", bus4.StallE, 0);
        idleCycle(); #2;
        checkOutput("lu count", bus4.LwStallCnt, 1);
        applyStimulus(0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0); #2;
        checkOutput("lu unused rs2", bus4.StallF, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0); #2;
        checkOutput("lu rd x0", bus4.StallF, 0);

        applyStimulus(0, 7, 0, 0, 7, 0, 0, 0, 1, 2'b01, 0, 0, 1, 0, 0); #2;
        checkOutput("br StallF", bus4.StallF, 0);
        checkOutput("br FlushD", bus4.FlushD, 1);
        checkOutput("br FlushE", bus4.FlushE, 1);
        idleCycle(); #2;
        checkOutput("br FlushCnt", bus4.FlushCnt, 1);

        mdCycle(1); #2;
        checkOutput("md c1 StallE", bus4.StallE, 1);
        checkOutput("md c1 FlushM", bus4.FlushM, 1);
        checkOutput("md c1 MdBusy", bus4.MdBusy, 0);
        checkOutput("md2 c1 StallE", bus2.StallE, 1);
        mdCycle(1); #2;
        checkOutput("md c2 StallF", bus4.StallF, 1);
        checkOutput("md c2 MdBusy", bus4.MdBusy, 1);
        checkOutput("md2 c2 StallE", bus2.StallE, 0);
        checkOutput("md2 c2 MdBusy", bus2.MdBusy, 1);
        mdCycle(1); #2;
        checkOutput("md c3 StallE", bus4.StallE, 1);
        checkOutput("md2 c3 restart", bus2.StallE, 1);
        mdCycle(1); #2;
        checkOutput("md c4 StallE", bus4.StallE, 0);
        checkOutput("md c4 StallF", bus4.StallF, 0);
        checkOutput("md c4 MdBusy", bus4.MdBusy, 1);
        mdCycle(1); #2;
        checkOutput("md b2b StallE", bus4.StallE, 1);
        checkOutput("md b2b MdBusy", bus4.MdBusy, 0);
        repeat (4) idleCycle();
        #2;
        checkOutput("md stall count", bus4.MdStallCnt, 6);
        checkOutput("md drained", bus4.MdBusy, 0);

        mdCycle(1);
        mdCycle(0); #1;
        checkOutput("rst pre StallE", bus4.StallE, 1);
        rst = 1'b1; #1;
        checkOutput("rst StallE", bus4.StallE, 0);
        checkOutput("rst StallF", bus4.StallF, 0);
        checkOutput("rst FlushM", bus4.FlushM, 0);
        checkOutput("rst MdBusy", bus4.MdBusy, 0);
        checkOutput("rst MdStallCnt", bus4.MdStallCnt, 0);
        checkOutput("rst FlushCnt", bus4.FlushCnt, 0);
        @(posedge clk); #1 rst = 1'b0;
        mdCycle(1); #2;
        checkOutput("fresh c1 StallE", bus4.StallE, 1);
        mdCycle(0); #2;
        checkOutput("fresh c2 MdBusy", bus4.MdBusy, 1);
        mdCycle(0); #2;
        checkOutput("fresh c3 StallE", bus4.StallE, 1);
        mdCycle(0); #2;
        checkOutput("fresh c4 StallE", bus4.StallE, 0);
        mdCycle(0); #2;
        checkOutput("fresh MdStallCnt", bus4.MdStallCnt, 3);

        repeat (20) loadUse(0);
        idleCycle(); #2;
        checkOutput("sat LwStallCnt", bus2.LwStallCnt, 15);
        loadUse(1);
        idleCycle(); #2;
        checkOutput("clr LwStallCnt", bus2.LwStallCnt, 0);

        repeat (3000) begin
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 63) == 0));
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
        repeat (3) idleCycle();
        @(posedge clk); #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
